// File: rtl/ei_tdp_ram_core_if.sv
// Bus bundle for the true dual-port RAM: two independent read/write ports
// plus the init and collision status lines.
interface ei_tdp_ram_core_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic                  we_a;
    logic                  re_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] out_a;
    logic                  rd_valid_a;

    logic                  we_b;
    logic                  re_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_b;
    logic [DATA_WIDTH-1:0] out_b;
    logic                  rd_valid_b;

    logic                  init_busy;
    logic                  coll_flag;

    modport master (
        output we_a, re_a, addr_a, data_a,
        output we_b, re_b, addr_b, data_b,
        input  out_a, rd_valid_a, out_b, rd_valid_b,
        input  init_busy, coll_flag
    );

    modport slave (
        input  we_a, re_a, addr_a, data_a,
        input  we_b, re_b, addr_b, data_b,
        output out_a, rd_valid_a, out_b, rd_valid_b,
        output init_busy, coll_flag
    );
endinterface

// File: rtl/ei_tdp_ram_core.sv
// True dual-port RAM with a post-reset clearing sweep, read-first ports and
// port-A-wins write collision handling flagged on coll_flag.
module ei_tdp_ram_core #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               resetn,
    ei_tdp_ram_core_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH / 2 - 1);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_reg;
    logic [PTR_W-1:0]  init_ptr_reg;
    logic              coll_reg;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready;
    logic [ADDR_WIDTH-1:0] init_addr_a;
    logic [ADDR_WIDTH-1:0] init_addr_b;
    logic                  same_addr;
    logic                  coll_next;

    logic                  wr_en_a;
    logic                  wr_en_b;
    logic [ADDR_WIDTH-1:0] wr_addr_a;
    logic [ADDR_WIDTH-1:0] wr_addr_b;
    logic [DATA_WIDTH-1:0] wr_data_a;
    logic [DATA_WIDTH-1:0] wr_data_b;

    logic                  re_p     [2];
    logic [ADDR_WIDTH-1:0] addr_p   [2];
    logic [DATA_WIDTH-1:0] out_reg  [2];
    logic                  rd_valid_reg [2];

    assign ready       = (state_reg == READY);
    assign init_addr_a = ADDR_WIDTH'({init_ptr_reg, 1'b0});
    assign init_addr_b = ADDR_WIDTH'({init_ptr_reg, 1'b1});
    assign same_addr   = (bus.addr_a == bus.addr_b);

    // A conflict needs at least one writer; two readers on one word are harmless.
    assign coll_next = ready && same_addr &&
                       ((bus.we_a && (bus.we_b || bus.re_b)) ||
                        (bus.we_b && (bus.we_a || bus.re_a)));

    always_comb begin
        wr_en_a   = 1'b0;
        wr_en_b   = 1'b0;
        wr_addr_a = bus.addr_a;
        wr_addr_b = bus.addr_b;
        wr_data_a = bus.data_a;
        wr_data_b = bus.data_b;
        if (!ready) begin
            wr_en_a   = 1'b1;
            wr_en_b   = 1'b1;
            wr_addr_a = init_addr_a;
            wr_addr_b = init_addr_b;
            wr_data_a = '0;
            wr_data_b = '0;
        end else begin
            wr_en_a = bus.we_a;
            wr_en_b = bus.we_b && !(bus.we_a && same_addr);
        end
    end

    // Storage is never reset; the INIT sweep provides the known contents.
    always_ff @(posedge clk) begin
        if (wr_en_a) mem[wr_addr_a] <= wr_data_a;
        if (wr_en_b) mem[wr_addr_b] <= wr_data_b;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= INIT;
            init_ptr_reg <= '0;
            coll_reg     <= 1'b0;
        end else begin
            coll_reg <= coll_next;
            case (state_reg)
                INIT: begin
                    init_ptr_reg <= init_ptr_reg + 1'b1;
                    if (init_ptr_reg == PTR_LAST) begin
                        state_reg <= READY;
                    end
                end
                READY: begin
                    state_reg <= READY;
                end
                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

    assign re_p[0]   = bus.re_a;
    assign re_p[1]   = bus.re_b;
    assign addr_p[0] = bus.addr_a;
    assign addr_p[1] = bus.addr_b;

    // Non-blocking read against the same-edge write gives read-first ordering.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                out_reg[gi]      <= '0;
                rd_valid_reg[gi] <= 1'b0;
            end else begin
                rd_valid_reg[gi] <= ready && re_p[gi];
                if (ready && re_p[gi]) begin
                    out_reg[gi] <= mem[addr_p[gi]];
                end
            end
        end
    end

    assign bus.out_a      = out_reg[0];
    assign bus.out_b      = out_reg[1];
    assign bus.rd_valid_a = rd_valid_reg[0];
    assign bus.rd_valid_b = rd_valid_reg[1];
    assign bus.init_busy  = !ready;
    assign bus.coll_flag  = coll_reg;
endmodule
